spi_rx_slave: RTL and testbench

- SPI slave receiver; the far end of the team's 16-bit MSB-first SPI master (active-low CS, master-generated SCLK, data shifted on SCLK rising edge).
- Deserialises SPI_DATA into parallel words and presents them on a valid/ready interface with a one-word holding register.
- Flags aborted frames and overruns.
- Sits on the peripheral side of the SPI link, driving local register or FIFO logic.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_rx_slave_if.sv | 30 +++
 rtl/spi_in_sync.sv | 60 ++++++
 rtl/spi_rx_slave.sv | 127 ++++++++++++
 tb/tb_spi_rx_slave.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width, FSM encoding and chip-select polarity.
package spi_pkg;

   localparam int unsigned SPI_WIDTH = 16;

   // FSM encoding kept as plain constants so the master and slave FSMs share one style
   typedef logic [0:0] spi_state_t;
   localparam spi_state_t SPI_IDLE = 1'b0;
   localparam spi_state_t SPI_RECV = 1'b1;

   localparam logic CS_ACTIVE = 1'b0;

endpackage

// File: rtl/spi_rx_slave_if.sv
// SPI receive bus plus the parallel valid/ready word interface of the slave receiver.
interface spi_rx_slave_if
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH = SPI_WIDTH
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic             spi_cs_n;
   logic             spi_sclk;
   logic             spi_data;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             frame_err;
   logic             overrun;
   logic [CNT_W-1:0] bit_count;

   modport slave (
      input  spi_cs_n, spi_sclk, spi_data, rx_ready,
      output rx_data, rx_valid, frame_err, overrun, bit_count
   );

   modport master (
      output spi_cs_n, spi_sclk, spi_data, rx_ready,
      input  rx_data, rx_valid, frame_err, overrun, bit_count
   );

endinterface

// File: rtl/spi_in_sync.sv
// SPI input conditioning: synchroniser chains, SCLK rise detect and one-clk-delayed data.
module spi_in_sync
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic spi_cs_n,
   input  logic spi_sclk,
   input  logic spi_data,
   output logic cs_s,
   output logic sclk_rise,
   output logic data_d
);

   // Bit order {cs_n, sclk, data}; idle levels loaded on reset
   localparam logic [2:0] IDLE_LEVEL = {~CS_ACTIVE, 1'b0, 1'b0};

   logic [2:0] in_raw;
   logic [2:0] in_s;
   logic       sclk_d;
   logic       data_dq;

   assign in_raw = {spi_cs_n, spi_sclk, spi_data};

   if (SYNC_STAGES == 0) begin : g_bypass
      assign in_s = in_raw;
   end else begin : g_sync
      logic [2:0] stage_q [SYNC_STAGES];

      // Identical flop chains for all three inputs keep them mutually aligned
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= IDLE_LEVEL;
         end else begin
            stage_q[0] <= in_raw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign in_s = stage_q[SYNC_STAGES-1];
   end

   // Delay flops: sclk for edge detect, data so the bit before the SCLK rise is captured
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_d  <= 1'b0;
         data_dq <= 1'b0;
      end else begin
         sclk_d  <= in_s[1];
         data_dq <= in_s[0];
      end
   end

   assign cs_s      = in_s[2];
   assign sclk_rise = in_s[1] & ~sclk_d;
   assign data_d    = data_dq;

endmodule

// File: rtl/spi_rx_slave.sv
// SPI slave receiver: deserialises MSB-first words into a one-word valid/ready holding register.
module spi_rx_slave
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH       = SPI_WIDTH,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic           clk,
   input logic           reset,
   spi_rx_slave_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic cs_s;
   logic sclk_rise;
   logic data_d;

   spi_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_in_sync (
      .clk       (clk),
      .reset     (reset),
      .spi_cs_n  (bus.spi_cs_n),
      .spi_sclk  (bus.spi_sclk),
      .spi_data  (bus.spi_data),
      .cs_s      (cs_s),
      .sclk_rise (sclk_rise),
      .data_d    (data_d)
   );

   spi_state_t       state_q, state_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] bit_count_q, bit_count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             cs_idle;
   logic             word_done;
   logic [WIDTH-1:0] word;

   assign cs_idle = (cs_s != CS_ACTIVE);
   assign word    = {shift_q[WIDTH-2:0], data_d};

   // FSM and shifter: CS deassertion takes priority over a coincident SCLK rise
   always_comb begin
      state_d     = state_q;
      bit_count_d = bit_count_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      word_done   = 1'b0;
      // A frame already running when reset releases is ignored until CS has been seen high
      armed_d     = armed_q | cs_idle;
      case (state_q)
         SPI_IDLE: begin
            bit_count_d = '0;
            if (!cs_idle && armed_q) state_d = SPI_RECV;
         end
         SPI_RECV: begin
            if (cs_idle) begin
               state_d     = SPI_IDLE;
               bit_count_d = '0;
               shift_d     = '0;
               frame_err_d = (bit_count_q != '0);
            end else if (sclk_rise) begin
               shift_d = word;
               if (bit_count_q == LAST_BIT) begin
                  word_done   = 1'b1;
                  bit_count_d = '0;
               end else begin
                  bit_count_d = bit_count_q + 1'b1;
               end
            end
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   // Holding register: a completed word loads if the slot is free or being drained this cycle
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
      if (word_done) begin
         if (!rx_valid_q || bus.rx_ready) begin
            rx_data_d  = word;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SPI_IDLE;
         armed_q     <= 1'b0;
         bit_count_q <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         bit_count_q <= bit_count_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_spi_rx_slave.sv
// Bench for spi_rx_slave: cycle-accurate SPI master model driving two instances
// (SYNC_STAGES 0 and 2), with an expected-word scoreboard checked against accepted words.
module tb_spi_rx_slave;
   import spi_pkg::*;

   localparam int unsigned W     = 16;
   localparam int unsigned SYNC0 = 0;
   localparam int unsigned SYNC1 = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   spi_rx_slave_if #(.WIDTH(W)) bus0 ();
   spi_rx_slave_if #(.WIDTH(W)) bus1 ();

   spi_rx_slave #(
      .WIDTH       (W),
      .SYNC_STAGES (SYNC0)
   ) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   spi_rx_slave #(
      .WIDTH       (W),
      .SYNC_STAGES (SYNC1)
   ) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [W-1:0] exp_q [2][$];
   logic [W-1:0] got_q [2][$];
   int acc [2];
   int fe  [2];
   int ov  [2];
   int t_rise  [2];
   int t_valid [2];
   logic prev_v [2];

   // Edge counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitors: record accepted words, flag pulses and the cycle rx_valid rises
   always @(negedge clk) begin
      if (!reset) begin
         if (bus0.rx_valid && !prev_v[0]) t_valid[0] = cyc;
         if (bus0.rx_valid && bus0.rx_ready) begin
            acc[0]++;
            got_q[0].push_back(bus0.rx_data);
         end
         if (bus0.frame_err) fe[0]++;
         if (bus0.overrun) ov[0]++;
         if (bus1.rx_valid && !prev_v[1]) t_valid[1] = cyc;
         if (bus1.rx_valid && bus1.rx_ready) begin
            acc[1]++;
            got_q[1].push_back(bus1.rx_data);
         end
         if (bus1.frame_err) fe[1]++;
         if (bus1.overrun) ov[1]++;
      end
      prev_v[0] = bus0.rx_valid;
      prev_v[1] = bus1.rx_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_pins(input int dut, input logic cs, input logic sclk, input logic dat);
      if (dut == 0) begin
         bus0.spi_cs_n = cs;
         bus0.spi_sclk = sclk;
         bus0.spi_data = dat;
      end else begin
         bus1.spi_cs_n = cs;
         bus1.spi_sclk = sclk;
         bus1.spi_data = dat;
      end
   endtask

   task automatic start_frame(input int dut, input logic [W-1:0] word, input int half);
      set_pins(dut, 1'b0, 1'b0, word[W-1]);
      tick(half);
   endtask

   // Master shifts the next bit out on the same clk that SCLK rises
   task automatic send_bits(input int dut, input logic [W-1:0] word, input int from, input int to,
                            input int half, input bit chk);
      logic nxt;
      for (int i = from; i < to; i++) begin
         if (chk) check($sformatf("bit_count before rise %0d", i), 32'(bus0.bit_count), 32'(i));
         nxt = (i < int'(W) - 1) ? word[int'(W) - 2 - i] : 1'b0;
         set_pins(dut, 1'b0, 1'b1, nxt);
         if (i == int'(W) - 1) t_rise[dut] = cyc;
         tick(half);
         set_pins(dut, 1'b0, 1'b0, nxt);
         tick(half);
      end
   endtask

   task automatic end_frame(input int dut, input int gap);
      set_pins(dut, 1'b1, 1'b0, 1'b0);
      tick(gap);
   endtask

   task automatic full_frame(input int dut, input logic [W-1:0] word, input int half, input int gap,
                             input bit chk, input bit push);
      start_frame(dut, word, half);
      send_bits(dut, word, 0, int'(W), half, chk);
      if (push) exp_q[dut].push_back(word);
      end_frame(dut, gap);
   endtask

   // Scoreboard drain: bounded wait, then count and in-order word comparison
   task automatic expect_words(input int dut);
      for (int k = 0; k < 60 && got_q[dut].size() < exp_q[dut].size(); k++) tick(1);
      check($sformatf("dut%0d word count", dut), 32'(got_q[dut].size()),
            32'(exp_q[dut].size()));
      while (exp_q[dut].size() > 0 && got_q[dut].size() > 0) begin
         check($sformatf("dut%0d rx_data", dut), 32'(got_q[dut].pop_front()),
               32'(exp_q[dut].pop_front()));
      end
      exp_q[dut].delete();
      got_q[dut].delete();
   endtask

   initial begin
      logic [W-1:0] seq [6];
      int acc_s, fe_s, ov_s;
      seq = '{16'hA569, 16'h2563, 16'h9B63, 16'h6A61, 16'hA265, 16'h7564};
      for (int d = 0; d < 2; d++) begin
         acc[d] = 0; fe[d] = 0; ov[d] = 0; t_rise[d] = 0; t_valid[d] = 0; prev_v[d] = 1'b0;
      end
      reset = 1'b1;
      set_pins(0, 1'b1, 1'b0, 1'b0);
      set_pins(1, 1'b1, 1'b0, 1'b0);
      bus0.rx_ready = 1'b1;
      bus1.rx_ready = 1'b1;
      tick(3);

      // Reset state
      check("reset rx_data", 32'(bus0.rx_data), 32'h0);
      check("reset rx_valid", 32'(bus0.rx_valid), 32'h0);
      check("reset bit_count", 32'(bus0.bit_count), 32'h0);
      check("reset frame_err", 32'(bus0.frame_err), 32'h0);
      check("reset overrun", 32'(bus0.overrun), 32'h0);
      reset = 1'b0;
      tick(3);

      // Single word, bit_count walk and one-clk latency
      full_frame(0, 16'hA569, 1, 2, 1'b1, 1'b1);
      check("bit_count after word", 32'(bus0.bit_count), 32'h0);
      expect_words(0);
      check("latency sync0", 32'(t_valid[0] - t_rise[0]), 32'(SYNC0 + 1));
      check("single frame_err", 32'(fe[0]), 32'h0);
      check("single overrun", 32'(ov[0]), 32'h0);

      // Six words with one-clk CS-high gaps
      acc_s = acc[0];
      for (int k = 0; k < 6; k++) full_frame(0, seq[k], 1, 1, 1'b0, 1'b1);
      expect_words(0);
      check("six acceptances", 32'(acc[0] - acc_s), 32'd6);
      check("six frame_err", 32'(fe[0]), 32'h0);
      check("six overrun", 32'(ov[0]), 32'h0);

      // Overrun: consumer stalled across two words
      bus0.rx_ready = 1'b0;
      full_frame(0, 16'hA569, 1, 2, 1'b0, 1'b1);
      full_frame(0, 16'h2563, 1, 2, 1'b0, 1'b0);
      tick(2);
      check("overrun pulses", 32'(ov[0]), 32'd1);
      check("overrun rx_valid held", 32'(bus0.rx_valid), 32'h1);
      check("overrun rx_data held", 32'(bus0.rx_data), 32'hA569);
      bus0.rx_ready = 1'b1;
      tick(1);
      bus0.rx_ready = 1'b0;
      check("rx_valid cleared", 32'(bus0.rx_valid), 32'h0);
      expect_words(0);
      bus0.rx_ready = 1'b1;

      // Aborted frame after 8 bits, then a clean frame
      fe_s  = fe[0];
      acc_s = acc[0];
      start_frame(0, 16'h9B63, 1);
      send_bits(0, 16'h9B63, 0, 8, 1, 1'b0);
      end_frame(0, 2);
      check("abort frame_err", 32'(fe[0] - fe_s), 32'd1);
      check("abort no word", 32'(acc[0] - acc_s), 32'd0);
      full_frame(0, 16'h6A61, 1, 2, 1'b0, 1'b1);
      expect_words(0);
      check("abort frame_err once", 32'(fe[0] - fe_s), 32'd1);

      // Reset mid-frame, released with CS still low
      fe_s  = fe[0];
      ov_s  = ov[0];
      start_frame(0, 16'hA265, 1);
      send_bits(0, 16'hA265, 0, 5, 1, 1'b1);
      check("bit_count before reset", 32'(bus0.bit_count), 32'd5);
      reset = 1'b1;
      #1;
      check("async reset rx_data", 32'(bus0.rx_data), 32'h0);
      check("async reset rx_valid", 32'(bus0.rx_valid), 32'h0);
      check("async reset bit_count", 32'(bus0.bit_count), 32'h0);
      tick(2);
      reset = 1'b0;
      acc_s = acc[0];
      send_bits(0, 16'hA265, 5, int'(W), 1, 1'b0);
      check("ignored frame bit_count", 32'(bus0.bit_count), 32'h0);
      end_frame(0, 2);
      check("ignored frame no word", 32'(acc[0] - acc_s), 32'd0);
      check("ignored frame no flag", 32'(fe[0] - fe_s), 32'd0);
      full_frame(0, 16'hA265, 1, 2, 1'b0, 1'b1);
      expect_words(0);
      check("post reset overrun", 32'(ov[0] - ov_s), 32'd0);

      // Synchronised instance, slow SCLK
      full_frame(1, 16'h7564, 4, 4, 1'b0, 1'b1);
      expect_words(1);
      check("latency sync2", 32'(t_valid[1] - t_rise[1]), 32'(SYNC1 + 1));
      check("sync2 rx_data", 32'(bus1.rx_data), 32'h7564);
      check("sync2 flags", 32'(fe[1] + ov[1]), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
